instr_line_buffer: RTL and testbench

INSTR_LINE_BUFFER -- requirements
Module: instr_line_buffer

---
 rtl/instr_lb_pkg.sv | 13 +
 rtl/instr_line_buffer_if.sv | 26 ++
 rtl/instr_line_buffer_sat_counter.sv | 20 ++
 rtl/instr_line_buffer.sv | 113 +++++++++++
 tb/tb_instr_line_buffer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_lb_pkg.sv
// Shared types and line geometry for the single-line instruction buffer.
package instr_lb_pkg;

  localparam int LINE_BYTES     = 16;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSHED_FILL
  } lb_state_e;

endpackage

// File: rtl/instr_line_buffer_if.sv
// Core fetch handshake plus the line-wide instruction RAM port.
interface instr_line_buffer_if #(
  parameter int ADDR_WIDTH = 20
);

  logic                  instr_req_i;
  logic [31:0]           instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [31:0]           instr_rdata_o;
  logic                  ram_en_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [127:0]          ram_rdata_i;

  // master: core and RAM side; slave: the line buffer
  modport master (
    output instr_req_i, instr_addr_i, ram_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, ram_en_o, ram_addr_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i, ram_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, ram_en_o, ram_addr_o
  );

endinterface

// File: rtl/instr_line_buffer_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/instr_line_buffer.sv
// One-line instruction buffer: hits answer from the held line, misses fetch a
// full 16-byte line from RAM and the core retries into a hit.
module instr_line_buffer
  import instr_lb_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  instr_line_buffer_if.slave   bus,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
);

  localparam int TAG_W = ADDR_WIDTH - 4;

  lb_state_e                         state, state_nxt;
  logic                              valid;
  logic [TAG_W-1:0]                  tag, pend_tag;
  logic [WORDS_PER_LINE-1:0][31:0]   line;
  logic [TAG_W-1:0]                  req_tag;
  logic [1:0]                        word_sel;
  logic                              gnt, ram_en, hit_inc, miss_inc, fill, clr_valid;
  logic                              unused_addr;

  assign req_tag     = bus.instr_addr_i[ADDR_WIDTH-1:4];
  assign word_sel    = bus.instr_addr_i[3:2];
  assign unused_addr = ^{bus.instr_addr_i[31:ADDR_WIDTH], bus.instr_addr_i[1:0]};

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    gnt       = 1'b0;
    ram_en    = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    fill      = 1'b0;
    clr_valid = 1'b0;
    // Handshake outputs are combinational, so gate them off while reset is held.
    if (rst_n) begin
      unique case (state)
        ST_IDLE: begin
          if (flush_i) begin
            clr_valid = 1'b1;
          end else if (bus.instr_req_i) begin
            if (valid && (tag == req_tag)) begin
              gnt     = 1'b1;
              hit_inc = 1'b1;
            end else begin
              ram_en    = 1'b1;
              miss_inc  = 1'b1;
              state_nxt = ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (flush_i) begin
            state_nxt = ST_FLUSHED_FILL;
          end else begin
            fill      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_FLUSHED_FILL: state_nxt = ST_IDLE;
        default:         state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      valid              <= 1'b0;
      tag                <= '0;
      pend_tag           <= '0;
      line               <= '0;
      bus.instr_rvalid_o <= 1'b0;
      bus.instr_rdata_o  <= '0;
    end else begin
      state              <= state_nxt;
      bus.instr_rvalid_o <= gnt;
      if (gnt)       bus.instr_rdata_o <= line[word_sel];
      if (miss_inc)  pend_tag          <= req_tag;
      if (clr_valid) valid             <= 1'b0;
      if (fill) begin
        line  <= bus.ram_rdata_i;
        tag   <= pend_tag;
        valid <= 1'b1;
      end
    end
  end

  assign bus.instr_gnt_o = gnt;
  assign bus.ram_en_o    = ram_en;
  assign bus.ram_addr_o  = {req_tag, 4'b0000};

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .count (hit_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .count (miss_cnt_o)
  );

endmodule

// File: tb/tb_instr_line_buffer.sv
// Directed bench with a scoreboard queue of expected fetch words; a monitor
// pops and compares on every instr_rvalid_o.
module tb_instr_line_buffer;

  localparam int AW = 20;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [CW-1:0] hit_cnt, miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];

  instr_line_buffer_if #(.ADDR_WIDTH(AW)) bus();

  instr_line_buffer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .bus        (bus),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: word k of line L reads as {4'hD, k, 4'h0, L}; garbage when not enabled
  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      for (int k = 0; k < 4; k++)
        bus.ram_rdata_i[32*k +: 32] <= {4'hD, 4'(k), 4'h0, bus.ram_addr_o};
    end else begin
      bus.ram_rdata_i <= {4{32'hBAD0_BAD0}};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int hits, input int misses);
    check({tag, "_hit_cnt"},  32'(hit_cnt),  32'(hits));
    check({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(misses));
  endtask

  // Monitor: rvalid exactly one cycle after gnt, data from the scoreboard, hold otherwise
  logic        gnt_prev;
  logic [31:0] last_rdata;
  always @(negedge clk) begin
    if (!rst_n) begin
      gnt_prev   = 1'b0;
      last_rdata = '0;
    end else begin
      if (bus.instr_rvalid_o || gnt_prev)
        check("rvalid_after_gnt", 32'(bus.instr_rvalid_o), 32'(gnt_prev));
      if (bus.instr_rvalid_o) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rvalid: got 0x%08h expected none", bus.instr_rdata_o);
        end else begin
          check("rdata", bus.instr_rdata_o, sb.pop_front());
        end
        last_rdata = bus.instr_rdata_o;
      end else begin
        check("rdata_hold", bus.instr_rdata_o, last_rdata);
      end
      gnt_prev = bus.instr_gnt_o;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the grant with req still high.
  task automatic fetch(input logic [31:0] a, input bit miss, input logic [31:0] exp_word);
    bit got = 1'b0;
    int lat = 0;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = a;
    sb.push_back(exp_word);
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("ram_en_first_cycle", 32'(bus.ram_en_o), 32'(miss));
        if (miss) check("ram_addr", 32'(bus.ram_addr_o), {12'h0, a[19:4], 4'h0});
      end
      if (bus.instr_gnt_o) begin
        got = 1'b1;
        lat = c;
      end
      @(posedge clk); #1;
    end
    check("gnt_latency", got ? 32'(lat) : 32'hFFFF_FFFF, miss ? 32'd2 : 32'd0);
  endtask

  task automatic idle(input int n);
    bus.instr_req_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    flush            = 1'b0;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_gnt",    32'(bus.instr_gnt_o),    0);
    check("reset_ram_en", 32'(bus.ram_en_o),       0);
    check("reset_rvalid", 32'(bus.instr_rvalid_o), 0);
    check("reset_rdata",  bus.instr_rdata_o,       0);
    check_cnt("reset", 0, 0);
    bus.instr_req_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss; the retry after the fill is counted as a hit
    fetch(32'h100, 1'b1, 32'hD000_0100);
    check_cnt("cold_miss", 1, 1);

    // Back-to-back hits on the same line: three more hits on top of the retry
    fetch(32'h104, 1'b0, 32'hD100_0100);
    fetch(32'h108, 1'b0, 32'hD200_0100);
    fetch(32'h10C, 1'b0, 32'hD300_0100);
    idle(1);
    check_cnt("b2b_hits", 4, 1);

    // Line change
    fetch(32'h110, 1'b1, 32'hD000_0110);
    idle(1);
    check_cnt("line_change", 5, 2);

    // Flush in IDLE with a would-be hit pending: no gnt, no RAM read, counters frozen
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h114;
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_gnt",    32'(bus.instr_gnt_o), 0);
    check("flush_idle_ram_en", 32'(bus.ram_en_o),    0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.instr_req_i = 1'b0;
    check_cnt("flush_idle", 5, 2);
    @(posedge clk); #1;
    fetch(32'h114, 1'b1, 32'hD100_0110);
    idle(1);
    check_cnt("after_flush", 6, 3);

    // Address wiggling with req low must not start anything
    for (int i = 0; i < 3; i++) begin
      bus.instr_addr_i = 32'h500 + 32'(i) * 32'h100;
      @(negedge clk);
      check("noreq_ram_en", 32'(bus.ram_en_o),    0);
      check("noreq_gnt",    32'(bus.instr_gnt_o), 0);
      @(posedge clk); #1;
    end
    check_cnt("noreq", 6, 3);

    // Flush during FILL: miss, FILL(flush), FLUSHED_FILL, miss again, FILL, gnt
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h200;
    sb.push_back(32'hD000_0200);
    @(negedge clk);
    check("ff_miss1_ram_en", 32'(bus.ram_en_o), 1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("ff_fill_gnt", 32'(bus.instr_gnt_o), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("ff_flushed_gnt",    32'(bus.instr_gnt_o), 0);
    check("ff_flushed_ram_en", 32'(bus.ram_en_o),    0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ff_miss2_ram_en", 32'(bus.ram_en_o),   1);
    check("ff_miss2_addr",   32'(bus.ram_addr_o), 32'h200);
    @(posedge clk); #1;
    @(negedge clk);
    check("ff_fill2_gnt", 32'(bus.instr_gnt_o), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ff_retry_gnt", 32'(bus.instr_gnt_o), 1);
    @(posedge clk); #1;
    idle(1);
    check_cnt("flush_fill", 7, 5);

    // 20 hits push the 4-bit hit counter into saturation
    for (int i = 0; i < 20; i++)
      fetch(32'h200 + 32'(i % 4) * 4, 1'b0, 32'hD000_0200 | (32'(i % 4) << 24));
    idle(1);
    check_cnt("saturate", 15, 5);

    // Reset in the middle of a fill
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h300;
    @(negedge clk);
    check("rst_fill_ram_en", 32'(bus.ram_en_o), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_gnt",    32'(bus.instr_gnt_o),    0);
    check("rst_mid_ram_en", 32'(bus.ram_en_o),       0);
    check("rst_mid_rvalid", 32'(bus.instr_rvalid_o), 0);
    check("rst_mid_rdata",  bus.instr_rdata_o,       0);
    check_cnt("rst_mid", 0, 0);
    @(posedge clk); #1;
    bus.instr_req_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(32'h300, 1'b1, 32'hD000_0300);
    idle(3);
    check_cnt("after_reset", 1, 1);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
